ones_pattern_enum: RTL and testbench

//  Inverse of the 4-bit ones-counter LUT. Given a target ones-count K, emits every WIDTH-bit

---
 rtl/ones_pattern_enum_if.sv | 22 ++
 rtl/ones_pattern_enum.sv | 131 +++++++++++++
 tb/tb_ones_pattern_enum.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_enum_if.sv
// ----------------------------------------------------------------------------
// ones_pattern_enum_if
//   Output stream of the ones-pattern enumerator.
//   master : producer side (drives out_valid, pattern, last; samples out_ready)
//   slave  : consumer side (samples out_valid, pattern, last; drives out_ready)
// Signals
//   out_valid  1      pattern/last are valid
//   out_ready  1      consumer accepts the current pattern
//   pattern    WIDTH  word with exactly K set bits
//   last       1      pattern is the final word of the sequence
// ----------------------------------------------------------------------------
interface ones_pattern_enum_if #(
    parameter int WIDTH = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pattern;
    logic             last;

    modport master (output out_valid, output pattern, output last, input out_ready);
    modport slave  (input out_valid, input pattern, input last, output out_ready);
endinterface

// File: rtl/ones_pattern_enum.sv
// ----------------------------------------------------------------------------
// ones_pattern_enum
//   Enumerates every WIDTH-bit word with exactly K set bits, in ascending
//   numeric order, over a valid/ready stream. A candidate counter walks up
//   from 0 one value per cycle; each candidate whose popcount equals K is
//   presented on the stream until the consumer takes it.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a new enumeration (only honoured when idle)
//   count    in   target ones-count K, captured with an accepted start
//   busy     out  high whenever the block is not idle
//   done     out  one-cycle pulse at the end of an enumeration
//   err      out  K exceeded WIDTH; nothing was emitted (held until next start)
//   num      out  number of words handed over (held until next start)
//   ob       master side of the output stream (out_valid/out_ready/pattern/last)
// ----------------------------------------------------------------------------
module ones_pattern_enum #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CW-1:0]        count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH:0]       num,
    ones_pattern_enum_if.master  ob
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    k_q;
    logic [WIDTH-1:0] last_word;
    logic             match;

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // The largest word with K ones is K ones packed into the MSBs; it is
    // the final element of the ascending sequence. K=0 gives all zeros.
    always_comb begin
        last_word = '0;
        for (int i = 0; i < WIDTH; i++)
            last_word[i] = ((i + int'(k_q)) >= WIDTH);
    end

    assign match = (popcnt(cand) == k_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cand         <= '0;
            k_q          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            num          <= '0;
            ob.out_valid <= 1'b0;
            ob.pattern   <= '0;
            ob.last      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q  <= count;
                        num  <= '0;
                        cand <= '0;
                        busy <= 1'b1;
                        if (int'(count) > WIDTH) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= S_SCAN;
                        end
                    end
                end

                S_SCAN: begin
                    if (match) begin
                        ob.pattern <= cand;
                        ob.last    <= (cand == last_word);
                        state      <= S_EMIT;
                    end else begin
                        cand <= cand + WIDTH'(1);
                    end
                end

                // First EMIT cycle raises out_valid from the freshly loaded
                // pattern register; out_ready only counts once out_valid is up.
                S_EMIT: begin
                    if (!ob.out_valid) begin
                        ob.out_valid <= 1'b1;
                    end else if (ob.out_ready) begin
                        ob.out_valid <= 1'b0;
                        num          <= num + (WIDTH+1)'(1);
                        if (ob.last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cand  <= cand + WIDTH'(1);
                            state <= S_SCAN;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_pattern_enum.sv
module tb_ones_pattern_enum;
    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CW-1:0]    count;
    logic             busy, done, err;
    logic [WIDTH:0]   num;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    ones_pattern_enum_if #(.WIDTH(WIDTH)) ob ();

    ones_pattern_enum #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .count (count),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .num   (num),
        .ob    (ob.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference 4-bit ones counter
    function automatic int ones4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic push_expected(input int k);
        exp_q.delete();
        for (int v = 0; v < 16; v++)
            if (ones4(4'(v)) == k) exp_q.push_back(4'(v));
    endtask

    // Runs one enumeration. Returns the edge index of the first out_valid.
    task automatic run_seq(input int k, input logic [3:0] stall_pat, input int stall_n,
                           input bit poke, output int first_e);
        int e, h_prev, p_prev, stall_left, n_exp;
        bit done_seen, holding, prev_v;
        logic [3:0] held_p, ev;
        logic held_l;
        push_expected(k);
        n_exp = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1; count = CW'(k); ob.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0; first_e = -1; h_prev = -1; p_prev = 0; prev_v = 0;
        done_seen = 0; holding = 0; stall_left = stall_n; held_p = '0; held_l = 0;
        while (!done_seen && e < 200) begin
            ob.out_ready = 1'b1;
            if (ob.out_valid && ob.pattern == stall_pat && stall_left > 0) begin
                ob.out_ready = 1'b0;
                stall_left--;
            end
            if (poke && busy) begin
                start = (e % 3 == 0);
                count = 3'd3;
            end
            if (ob.out_valid) begin
                if (!prev_v) begin
                    if (first_e < 0) first_e = e;
                    else begin
                        checks++;
                        if (e != h_prev + (int'(ob.pattern) - p_prev) + 1) begin
                            failures++;
                            $display("FAIL gap_latency k=%0d: pattern %b at edge %0d, expected edge %0d",
                                     k, ob.pattern, e, h_prev + (int'(ob.pattern) - p_prev) + 1);
                        end
                    end
                end
                checks++;
                if (ones4(ob.pattern) != k) begin
                    failures++;
                    $display("FAIL popcount k=%0d: pattern %b has %0d ones", k, ob.pattern, ones4(ob.pattern));
                end
                if (holding) begin
                    checks++;
                    if (ob.pattern !== held_p || ob.last !== held_l) begin
                        failures++;
                        $display("FAIL stall_hold: got %b/%b, held %b/%b", ob.pattern, ob.last, held_p, held_l);
                    end
                end
                if (ob.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_word k=%0d: got %b, expected none", k, ob.pattern);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ob.pattern !== ev || ob.last !== (exp_q.size() == 0)) begin
                            failures++;
                            $display("FAIL word k=%0d: got %b last=%b, expected %b last=%b",
                                     k, ob.pattern, ob.last, ev, exp_q.size() == 0);
                        end
                    end
                    h_prev = e + 1; p_prev = int'(ob.pattern); holding = 0;
                end else begin
                    holding = 1; held_p = ob.pattern; held_l = ob.last;
                end
            end
            prev_v = ob.out_valid;
            if (done) begin
                done_seen = 1;
                checks++;
                if (err !== 1'b0 || num !== (WIDTH+1)'(n_exp) || exp_q.size() != 0 || e != h_prev) begin
                    failures++;
                    $display("FAIL done k=%0d: err=%b num=%0d left=%0d edge=%0d, expected err=0 num=%0d left=0 edge=%0d",
                             k, err, num, exp_q.size(), e, n_exp, h_prev);
                end
            end
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL timeout k=%0d: done not seen within 200 cycles", k);
        end else if (done !== 1'b0 || busy !== 1'b0 || ob.out_valid !== 1'b0 || num !== (WIDTH+1)'(n_exp)) begin
            failures++;
            $display("FAIL after_done k=%0d: done=%b busy=%b valid=%b num=%0d, expected 0 0 0 %0d",
                     k, done, busy, ob.out_valid, num, n_exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; count = '0; ob.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, num, ob.out_valid, ob.pattern, ob.last} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b err=%b num=%0d valid=%b pattern=%b last=%b, expected all 0",
                     busy, done, err, num, ob.out_valid, ob.pattern, ob.last);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_k_first(input int k, input int exp_first);
        int fe;
        run_seq(k, 4'd0, 0, 0, fe);
        checks++;
        if (fe != exp_first) begin
            failures++;
            $display("FAIL first_latency k=%0d: first valid at edge %0d, expected %0d", k, fe, exp_first);
        end
    endtask

    task automatic test_err;
        bit bad_v;
        @(posedge clk); #1;
        start = 1'b1; count = 3'd5; ob.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || num !== '0) begin
            failures++;
            $display("FAIL err_done: done=%b err=%b num=%0d, expected 1 1 0", done, err, num);
        end
        bad_v = ob.out_valid;
        repeat (4) begin
            @(posedge clk); #1;
            bad_v |= ob.out_valid;
        end
        checks++;
        if (bad_v || done !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || num !== '0) begin
            failures++;
            $display("FAIL err_after: valid_seen=%b done=%b busy=%b err=%b num=%0d, expected 0 0 0 1 0",
                     bad_v, done, busy, err, num);
        end
    endtask

    task automatic test_stall_and_poke;
        int fe;
        run_seq(1, 4'b0010, 5, 1, fe);
        checks++;
        if (fe != 3) begin
            failures++;
            $display("FAIL stall_first_latency: first valid at edge %0d, expected 3", fe);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        bit saw_done;
        @(posedge clk); #1;
        start = 1'b1; count = 3'd3; ob.out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!ob.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ob.out_valid) begin
            failures++;
            $display("FAIL mid_reset_setup: out_valid not seen within 50 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, num, ob.out_valid, ob.pattern, ob.last} !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: busy=%b done=%b err=%b num=%0d valid=%b pattern=%b last=%b, expected all 0",
                     busy, done, err, num, ob.out_valid, ob.pattern, ob.last);
        end
        saw_done = 0;
        repeat (2) begin @(posedge clk); #1; saw_done |= done; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; saw_done |= done | busy; end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL mid_reset_quiet: done/busy seen after reset, expected none");
        end
        test_k_first(3, 9);
    endtask

    initial begin
        test_reset();
        test_k_first(2, 5);
        test_k_first(0, 2);
        test_k_first(4, 17);
        test_err();
        test_stall_and_poke();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
